// File: rtl/accel_pkg.sv
// Shared definitions for the edge-detection accelerator Avalon-MM master:
// FSM state encoding and default bus/image dimensions.
package accel_pkg;

   // Default Avalon data/pixel width and word address width
   localparam int ACCEL_DW = 16;
   localparam int ACCEL_AW = 16;

   // One job covers a full 32x32 image
   localparam int ACCEL_NUM_PIXELS = 32 * 32;

   // Master FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/accel_hold_reg.sv
// One-entry valid/data holding register. A word is accepted only into an
// empty entry and is released by free_i; flush_i discards any held word.
module accel_hold_reg
   import accel_pkg::*;
#(
   parameter int DATA_WIDTH = ACCEL_DW
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  load_i,
   input  logic                  free_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;

   // Occupancy: set by a load into an empty entry, cleared by free, flush or reset
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         valid_q <= 1'b0;
      end else if (load_i && !valid_q) begin
         valid_q <= 1'b1;
      end else if (free_i && valid_q) begin
         valid_q <= 1'b0;
      end
   end

   // Payload captured only into an empty entry so it stays stable while presented
   always_ff @(posedge clk_i) begin
      if (load_i && !valid_q) begin
         data_q <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/avm_pixel_master.sv
// Avalon-MM master of the edge-detection accelerator. A rising edge on go
// starts a job: NUM_PIXELS words are read from IN_BASE+inputAdd_offset,
// streamed to the kernel, and the kernel results are written back to
// OUT_BASE+outputAdd_offset, followed by a one-cycle done pulse.
// Optional feature: define AVM_WAIT_TIMEOUT_EN to enable the waitrequest
// watchdog (TIMEOUT_CYCLES stalled cycles abort the job and set err).
module avm_pixel_master
   import accel_pkg::*;
#(
   parameter int DATA_WIDTH     = ACCEL_DW,
   parameter int ADDRESS_WIDTH  = ACCEL_AW,
   parameter int NUM_PIXELS     = ACCEL_NUM_PIXELS,
   parameter int IN_BASE        = 0,
   parameter int OUT_BASE       = 'h8000,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     CSI_CLOCK_CLK,
   input  logic                     CSI_CLOCK_RESET,
   input  logic                     go,
   input  logic [ADDRESS_WIDTH-1:0] inputAdd_offset,
   input  logic [ADDRESS_WIDTH-1:0] outputAdd_offset,
   output logic                     done,
   output logic                     busy,
   output logic                     err,
   output logic [ADDRESS_WIDTH-1:0] AVM_AVALONMASTER_ADDRESS,
   output logic                     AVM_AVALONMASTER_READ,
   output logic                     AVM_AVALONMASTER_WRITE,
   input  logic                     AVM_AVALONMASTER_WAITREQUEST,
   input  logic [DATA_WIDTH-1:0]    AVM_AVALONMASTER_READDATA,
   output logic [DATA_WIDTH-1:0]    AVM_AVALONMASTER_WRITEDATA,
   output logic [DATA_WIDTH-1:0]    pix_out_data,
   output logic                     pix_out_valid,
   input  logic                     pix_out_ready,
   input  logic [DATA_WIDTH-1:0]    pix_in_data,
   input  logic                     pix_in_valid,
   output logic                     pix_in_ready
);

   localparam int                       CNT_W      = $clog2(NUM_PIXELS + 1);
   localparam logic [CNT_W-1:0]         NUM_C      = CNT_W'(NUM_PIXELS);
   localparam logic [ADDRESS_WIDTH-1:0] IN_BASE_C  = ADDRESS_WIDTH'(IN_BASE);
   localparam logic [ADDRESS_WIDTH-1:0] OUT_BASE_C = ADDRESS_WIDTH'(OUT_BASE);

   logic [1:0]               state_q, state_d;
   logic                     go_q;
   logic [ADDRESS_WIDTH-1:0] in_off_q, out_off_q, addr_q;
   logic [CNT_W-1:0]         rd_cnt_q, wr_cnt_q;
   logic                     read_q, write_q;
   logic [DATA_WIDTH-1:0]    wdata_q;

   logic                     in_vld, out_vld;
   logic [DATA_WIDTH-1:0]    in_data, out_data;
   logic                     run, start, req_act, rd_done, wr_done;
   logic                     issue_wr, issue_rd, in_accept, out_accept, flush, timeout;

   assign run      = (state_q == ST_RUN);
   assign start    = (state_q == ST_IDLE) && go && !go_q;
   assign req_act  = read_q || write_q;
   assign rd_done  = read_q && !AVM_AVALONMASTER_WAITREQUEST;
   assign wr_done  = write_q && !AVM_AVALONMASTER_WAITREQUEST;
   // Writes drain the result hold first so the kernel is never blocked by reads
   assign issue_wr = run && !req_act && out_vld;
   assign issue_rd = run && !req_act && !out_vld && !in_vld && (rd_cnt_q < NUM_C);

   assign pix_out_valid = in_vld;
   assign pix_out_data  = in_data;
   assign out_accept    = in_vld && pix_out_ready;
   // Hold empty means nothing pending, so wr_cnt alone bounds the result count
   assign pix_in_ready  = run && !out_vld && (wr_cnt_q < NUM_C);
   assign in_accept     = pix_in_ready && pix_in_valid;
   assign flush         = start || timeout;

   assign done = (state_q == ST_FIN);
   assign busy = (state_q != ST_IDLE);

   assign AVM_AVALONMASTER_ADDRESS   = addr_q;
   assign AVM_AVALONMASTER_READ      = read_q;
   assign AVM_AVALONMASTER_WRITE     = write_q;
   assign AVM_AVALONMASTER_WRITEDATA = wdata_q;

   accel_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_in_hold (
      .clk_i   (CSI_CLOCK_CLK),
      .rst_i   (CSI_CLOCK_RESET),
      .flush_i (flush),
      .load_i  (rd_done),
      .free_i  (out_accept),
      .data_i  (AVM_AVALONMASTER_READDATA),
      .valid_o (in_vld),
      .data_o  (in_data)
   );

   accel_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_hold (
      .clk_i   (CSI_CLOCK_CLK),
      .rst_i   (CSI_CLOCK_RESET),
      .flush_i (flush),
      .load_i  (in_accept),
      .free_i  (wr_done),
      .data_i  (pix_in_data),
      .valid_o (out_vld),
      .data_o  (out_data)
   );

`ifdef AVM_WAIT_TIMEOUT_EN
   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_q;
   logic            err_q;

   assign timeout = req_act && AVM_AVALONMASTER_WAITREQUEST && (wd_q == WD_LAST);
   assign err     = err_q;

   // Count consecutive stalled cycles of the active request
   always_ff @(posedge CSI_CLOCK_CLK) begin
      if (CSI_CLOCK_RESET) begin
         wd_q <= '0;
      end else if (req_act && AVM_AVALONMASTER_WAITREQUEST && !timeout) begin
         wd_q <= wd_q + 1'b1;
      end else begin
         wd_q <= '0;
      end
   end

   // Sticky error: set by a watchdog abort, cleared by the next job start
   always_ff @(posedge CSI_CLOCK_CLK) begin
      if (CSI_CLOCK_RESET || start) begin
         err_q <= 1'b0;
      end else if (timeout) begin
         err_q <= 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout            = 1'b0;
   assign err                = 1'b0;
`endif

   // Next-state: run until every result is written and the bus is quiet
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN: begin
            if (timeout) begin
               state_d = ST_FIN;
            end else if ((wr_cnt_q == NUM_C) && !req_act) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register and go edge detector
   always_ff @(posedge CSI_CLOCK_CLK) begin
      if (CSI_CLOCK_RESET) begin
         state_q <= ST_IDLE;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         go_q    <= go;
      end
   end

   // Job offsets are frozen at start so the slave may change them mid-job
   always_ff @(posedge CSI_CLOCK_CLK) begin
      if (start) begin
         in_off_q  <= inputAdd_offset;
         out_off_q <= outputAdd_offset;
      end
   end

   // Read/write beat counters
   always_ff @(posedge CSI_CLOCK_CLK) begin
      if (CSI_CLOCK_RESET || start) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         if (rd_done) rd_cnt_q <= rd_cnt_q + 1'b1;
         if (wr_done) wr_cnt_q <= wr_cnt_q + 1'b1;
      end
   end

   // Bus command: held until waitrequest drops, then idle for one cycle
   always_ff @(posedge CSI_CLOCK_CLK) begin
      if (CSI_CLOCK_RESET) begin
         read_q  <= 1'b0;
         write_q <= 1'b0;
      end else if (timeout || rd_done || wr_done) begin
         read_q  <= 1'b0;
         write_q <= 1'b0;
      end else if (issue_wr) begin
         write_q <= 1'b1;
      end else if (issue_rd) begin
         read_q <= 1'b1;
      end
   end

   // Address/data loaded only at issue, so they stay stable through a stall
   always_ff @(posedge CSI_CLOCK_CLK) begin
      if (issue_wr) begin
         addr_q  <= OUT_BASE_C + out_off_q + ADDRESS_WIDTH'(wr_cnt_q);
         wdata_q <= out_data;
      end else if (issue_rd) begin
         addr_q  <= IN_BASE_C + in_off_q + ADDRESS_WIDTH'(rd_cnt_q);
      end
   end

endmodule
